cla_nibble_sequencer: RTL and testbench

Nibble-serial add controller that sequences the team's 4-bit carry-lookahead adder slice to add WIDTH-bit operands over WIDTH/4 clock cycles. A registered carry flip-flop links each nibble to the next. The block sits between an operand source and a result sink, with valid/ready handshakes on both sides. It is the scheduler that time-shares one CLA slice across all nibbles of a wide add.

---
 rtl/cla_nibble_sequencer_pkg.sv | 12 +
 rtl/cla_nibble_sequencer_cla4.sv | 28 ++
 rtl/cla_nibble_sequencer.sv | 140 ++++++++++++++
 tb/tb_cla_nibble_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial CLA add sequencer: slice width and FSM states.
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/cla_nibble_sequencer_cla4.sv
// Purely combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3 for overflow detection.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened from generate/propagate terms so no carry waits on another.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Time-shares one cla4 slice across WIDTH/4 nibbles of a wide add with valid/ready on both sides.
// Defining CLA_SEQ_OVF_EN adds the registered signed-overflow output ovf.
module cla_nibble_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SEQ_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [3:0]       sliceS;
    logic             sliceCo;
    logic             sliceC3;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
`else
    logic             unusedC3;
    assign unusedC3 = sliceC3;
`endif

    cla4 u_cla4 (
        .a  (aSh_q[3:0]),
        .b  (bSh_q[3:0]),
        .ci (carry_q),
        .s  (sliceS),
        .co (sliceCo),
        .c3 (sliceC3)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Partial sums build in acc so the visible sum only changes when a complete result lands.
    always_comb begin
        state_d = state_q;
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef CLA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    aSh_d   = a;
                    bSh_d   = b;
                    carry_d = cin;
                    k_d     = '0;
                end
            end
            RUN: begin
                aSh_d   = aSh_q >> NIBBLE_W;
                bSh_d   = bSh_q >> NIBBLE_W;
                acc_d   = WIDTH'({sliceS, acc_q} >> NIBBLE_W);
                carry_d = sliceCo;
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = HOLD;
                    sum_d   = acc_d;
                    cout_d  = sliceCo;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = sliceC3 ^ sliceCo;
`endif
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CLA_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Self-checking bench for cla_nibble_sequencer (WIDTH=16): directed literal cases plus
// randomized traffic checked every cycle against a cycle-count/arithmetic reference model.
module tb_cla_nibble_sequencer;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit             mKnown = 1'b0;
    bit             mBusy  = 1'b0;
    bit             mHold  = 1'b0;
    int             mDoneEdge = 0;
    logic [WIDTH-1:0] expSum  = '0;
    logic             expCout = 1'b0;
    logic             expOvf  = 1'b0;
    logic [WIDTH-1:0] pendSum;
    logic             pendCout;
    logic             pendOvf;

    cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_SEQ_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a result is the plain (WIDTH+1)-bit sum, ready NIBBLES edges after acceptance.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            mKnown  = 1'b1;
            mBusy   = 1'b0;
            mHold   = 1'b0;
            expSum  = '0;
            expCout = 1'b0;
            expOvf  = 1'b0;
        end else if (mKnown) begin
            if (mHold) begin
                if (out_ready) mHold = 1'b0;
            end else if (mBusy) begin
                if (cyc == mDoneEdge) begin
                    mBusy   = 1'b0;
                    mHold   = 1'b1;
                    expSum  = pendSum;
                    expCout = pendCout;
                    expOvf  = pendOvf;
                end
            end else if (in_valid) begin
                {pendCout, pendSum} = 17'(a) + 17'(b) + 17'(cin);
                pendOvf   = (a[WIDTH-1] == b[WIDTH-1]) && (pendSum[WIDTH-1] != a[WIDTH-1]);
                mDoneEdge = cyc + NIBBLES;
                mBusy     = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mKnown) begin
            checkOutput("in_ready", 32'(in_ready), 32'(!(mBusy || mHold)));
            checkOutput("out_valid", 32'(out_valid), 32'(mHold));
            checkOutput("sum", 32'(sum), 32'(expSum));
            checkOutput("cout", 32'(cout), 32'(expCout));
`ifdef CLA_SEQ_OVF_EN
            checkOutput("ovf", 32'(ovf), 32'(expOvf));
`endif
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_wait", 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic awaitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("result_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'h0000);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

        applyStimulus(16'h00FF, 16'h0001, 1'b0);
        awaitResult(lat);
        checkOutput("ripple_latency", 32'(lat), 32'd4);
        checkOutput("ripple_sum", 32'(sum), 32'h0100);
        checkOutput("ripple_cout", 32'(cout), 32'd0);
        @(negedge clk);

        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        awaitResult(lat);
        checkOutput("wrap_sum", 32'(sum), 32'h0000);
        checkOutput("wrap_cout", 32'(cout), 32'd1);
`ifdef CLA_SEQ_OVF_EN
        checkOutput("wrap_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);

        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        awaitResult(lat);
        checkOutput("smax_sum", 32'(sum), 32'h8000);
        checkOutput("smax_cout", 32'(cout), 32'd0);
`ifdef CLA_SEQ_OVF_EN
        checkOutput("smax_ovf", 32'(ovf), 32'd1);
`endif
        @(negedge clk);

        applyStimulus(16'h0000, 16'h0000, 1'b1);
        awaitResult(lat);
        checkOutput("cin_sum", 32'(sum), 32'h0001);
        checkOutput("cin_cout", 32'(cout), 32'd0);
        @(negedge clk);

        // Back-pressure with a stray second request that must be ignored.
        out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h1111, 1'b0);
        awaitResult(lat);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_sum", 32'(sum), 32'h2345);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            in_valid = (i == 2);
            a        = 16'hFFFF;
            b        = 16'hFFFF;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_done_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_done_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_done_sum", 32'(sum), 32'h2345);

        applyStimulus(16'hAAAA, 16'h5555, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("abort_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(16'h0F0F, 16'h00F1, 1'b0);
        awaitResult(lat);
        checkOutput("after_abort_sum", 32'(sum), 32'h1000);
        checkOutput("after_abort_cout", 32'(cout), 32'd0);
        @(negedge clk);

        // Random traffic; correctness is judged by the per-cycle model compare.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            b         = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            cin       = 1'($urandom);
            rst_n     = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
